// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, 3-sample majority, parity/stop options, valid/ready output.
// Define UART_RX_FIFO_EN for a DEPTH-entry output FIFO; otherwise a single holding register is used.
module uart_rx_param #(
    parameter int WIDTH     = 8,
    parameter int FCLK      = 50000000,
    parameter int FBAUD     = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             idle_o,
    output logic             frame_err_o,
    output logic             parity_err_o,
    output logic             overrun_o
);

    localparam int DIV_RAW = FCLK / (FBAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (WIDTH < 5 || WIDTH > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
            DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
            $error("uart_rx_param: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        sync_reg;
    logic [DW-1:0]     div_cnt_reg;
    logic [3:0]        sc_reg;
    logic              s7_reg, s8_reg;
    logic [3:0]        bit_cnt_reg;
    logic              stop_cnt_reg;
    logic [WIDTH-1:0]  shift_reg;
    logic              par_reg;
    logic              frame_err_reg, parity_err_reg, overrun_reg;

    logic rx_s, tick, at9, at15, bit_val, par_ok;
    logic start_det, shift_en, bit_inc, bit_clr, stop_inc, stop_clr, par_ld;
    logic push_good, ferr_set, perr_set, pop, buf_full;

    assign rx_s    = sync_reg[1];
    assign tick    = (div_cnt_reg == DW'(DIV - 1));
    assign at9     = tick && (sc_reg == 4'd9);
    assign at15    = tick && (sc_reg == 4'd15);
    assign bit_val = (s7_reg & s8_reg) | (s7_reg & rx_s) | (s8_reg & rx_s);
    assign pop     = valid_o && ready_i;

    always_comb begin
        par_ok = 1'b1;
        if (PARITY == 1)
            par_ok = (^shift_reg) ^ par_reg;
        else if (PARITY == 2)
            par_ok = ~((^shift_reg) ^ par_reg);
    end

    always_comb begin
        state_next = state_reg;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        bit_inc    = 1'b0;
        bit_clr    = 1'b0;
        stop_inc   = 1'b0;
        stop_clr   = 1'b0;
        par_ld     = 1'b0;
        push_good  = 1'b0;
        ferr_set   = 1'b0;
        perr_set   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    start_det  = 1'b1;
                end
            end
            S_START: begin
                if (at9 && bit_val) begin
                    state_next = S_IDLE;
                end else if (at15) begin
                    state_next = S_DATA;
                    bit_clr    = 1'b1;
                end
            end
            S_DATA: begin
                if (at9) begin
                    shift_en = 1'b1;
                end else if (at15) begin
                    if (bit_cnt_reg == 4'(WIDTH - 1)) begin
                        state_next = (PARITY != 0) ? S_PAR : S_STOP;
                        stop_clr   = 1'b1;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (at9)
                    par_ld = 1'b1;
                else if (at15)
                    state_next = S_STOP;
            end
            S_STOP: begin
                if (at9) begin
                    if (!bit_val) begin
                        ferr_set   = 1'b1;
                        state_next = S_BRK;
                    end else if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
                        // Leave half a bit early so the next start edge is never missed.
                        state_next = S_IDLE;
                        push_good  = par_ok;
                        perr_set   = ~par_ok;
                    end
                end else if (at15) begin
                    stop_inc = 1'b1;
                end
            end
            S_BRK: begin
                if (rx_s)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= S_IDLE;
            sync_reg       <= 2'b11;
            div_cnt_reg    <= '0;
            sc_reg         <= '0;
            s7_reg         <= 1'b1;
            s8_reg         <= 1'b1;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= 1'b0;
            shift_reg      <= '0;
            par_reg        <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            sync_reg  <= {sync_reg[0], rx_i};
            if (start_det) begin
                div_cnt_reg <= '0;
                sc_reg      <= '0;
            end else begin
                div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
                if (tick)
                    sc_reg <= sc_reg + 1'b1;
            end
            if (tick && sc_reg == 4'd7)
                s7_reg <= rx_s;
            if (tick && sc_reg == 4'd8)
                s8_reg <= rx_s;
            if (shift_en)
                shift_reg <= {bit_val, shift_reg[WIDTH-1:1]};
            if (bit_clr)
                bit_cnt_reg <= '0;
            else if (bit_inc)
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (stop_clr)
                stop_cnt_reg <= 1'b0;
            else if (stop_inc)
                stop_cnt_reg <= stop_cnt_reg + 1'b1;
            if (par_ld)
                par_reg <= bit_val;
            frame_err_reg  <= ferr_set;
            parity_err_reg <= perr_set;
            overrun_reg    <= push_good && buf_full && !pop;
        end
    end

    assign idle_o       = (state_reg == S_IDLE);
    assign frame_err_o  = frame_err_reg;
    assign parity_err_o = parity_err_reg;
    assign overrun_o    = overrun_reg;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [WIDTH-1:0] data_reg;
    logic             push_ok;

    assign buf_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign valid_o     = (wr_ptr_reg != rd_ptr_reg);
    assign push_ok     = push_good && (!buf_full || pop);
    assign rd_ptr_next = pop ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;
    assign data_o      = data_reg;

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
    end

    // The head register is refilled from the new head slot, bypassing a word written there this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            data_reg   <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            rd_ptr_reg <= rd_ptr_next;
            if (push_ok && wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0])
                data_reg <= shift_reg;
            else if (pop || push_ok)
                data_reg <= mem[rd_ptr_next[AW-1:0]];
        end
    end
`else
    logic [WIDTH-1:0] hold_reg;
    logic             full_reg;
    logic             push_ok;

    assign buf_full = full_reg;
    assign valid_o  = full_reg;
    assign push_ok  = push_good && (!full_reg || pop);
    assign data_o   = hold_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_reg <= '0;
            full_reg <= 1'b0;
        end else if (push_ok) begin
            hold_reg <= shift_reg;
            full_reg <= 1'b1;
        end else if (pop) begin
            full_reg <= 1'b0;
        end
    end
`endif

endmodule
